// File: rtl/riscv_program_loader.sv
// Byte-stream boot loader: frames of SYNC, N, 4*N little-endian payload bytes, CHK.
// Assembled words go out on the program-memory write port. The core is held in reset
// until a frame has loaded with a matching XOR checksum.
module riscv_program_loader #(
  parameter int unsigned ADDR_W = 5,
  parameter logic [7:0]  SYNC   = 8'hA5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              pm_we,
  output logic [ADDR_W-1:0] pm_addr,
  output logic [31:0]       pm_data,
  output logic              core_rst,
  output logic              load_done,
  output logic              load_error,
  output logic [ADDR_W:0]   words_loaded
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_COUNT = 3'd1;
  localparam logic [2:0] ST_LOAD  = 3'd2;
  localparam logic [2:0] ST_CHECK = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;
  localparam logic [2:0] ST_ERROR = 3'd5;

  logic [2:0]        state_q, state_d;
  logic [1:0]        byte_cnt_q, byte_cnt_d;
  logic [7:0]        chk_q, chk_d;
  logic [23:0]       word_q, word_d;
  logic [ADDR_W:0]   n_q, n_d;
  logic [ADDR_W:0]   words_loaded_q, words_loaded_d;
  logic              pm_we_q, pm_we_d;
  logic [ADDR_W-1:0] pm_addr_q, pm_addr_d;
  logic [31:0]       pm_data_q, pm_data_d;
  logic              core_rst_q, core_rst_d;
  logic              load_done_q, load_done_d;
  logic              load_error_q, load_error_d;
  logic              in_ready_q, in_ready_d;
  logic              xfer;

  assign xfer = in_valid & in_ready_q;

  // Next-state and output computation; everything advances only on an accepted byte.
  always_comb begin
    state_d        = state_q;
    byte_cnt_d     = byte_cnt_q;
    chk_d          = chk_q;
    word_d         = word_q;
    n_d            = n_q;
    words_loaded_d = words_loaded_q;
    pm_we_d        = 1'b0;
    pm_addr_d      = pm_addr_q;
    pm_data_d      = pm_data_q;
    core_rst_d     = core_rst_q;
    load_done_d    = load_done_q;
    load_error_d   = load_error_q;
    in_ready_d     = in_ready_q;

    case (state_q)
      ST_IDLE: begin
        if (xfer && in_data == SYNC) begin
          state_d = ST_COUNT;
        end
      end
      ST_COUNT: begin
        if (xfer) begin
          if (in_data == 8'h00 || 32'(in_data) > DEPTH) begin
            state_d      = ST_ERROR;
            load_error_d = 1'b1;
          end else begin
            n_d            = (ADDR_W+1)'(in_data);
            chk_d          = 8'h00;
            byte_cnt_d     = 2'd0;
            words_loaded_d = '0;
            state_d        = ST_LOAD;
          end
        end
      end
      ST_LOAD: begin
        if (xfer) begin
          chk_d      = chk_q ^ in_data;
          byte_cnt_d = byte_cnt_q + 2'd1;
          case (byte_cnt_q)
            2'd0:    word_d[7:0]   = in_data;
            2'd1:    word_d[15:8]  = in_data;
            2'd2:    word_d[23:16] = in_data;
            default: begin
              pm_we_d        = 1'b1;
              pm_addr_d      = words_loaded_q[ADDR_W-1:0];
              pm_data_d      = {in_data, word_q};
              words_loaded_d = words_loaded_q + (ADDR_W+1)'(1);
              if (words_loaded_d == n_q) begin
                state_d = ST_CHECK;
              end
            end
          endcase
        end
      end
      ST_CHECK: begin
        if (xfer) begin
          if (in_data == chk_q) begin
            state_d     = ST_DONE;
            load_done_d = 1'b1;
            core_rst_d  = 1'b0;
            in_ready_d  = 1'b0;
          end else begin
            state_d      = ST_ERROR;
            load_error_d = 1'b1;
          end
        end
      end
      ST_DONE: begin
      end
      ST_ERROR: begin
        if (xfer && in_data == SYNC) begin
          state_d      = ST_COUNT;
          load_error_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      byte_cnt_q     <= 2'd0;
      chk_q          <= 8'h00;
      word_q         <= 24'h0;
      n_q            <= '0;
      words_loaded_q <= '0;
      pm_we_q        <= 1'b0;
      pm_addr_q      <= '0;
      pm_data_q      <= 32'h0;
      core_rst_q     <= 1'b1;
      load_done_q    <= 1'b0;
      load_error_q   <= 1'b0;
      in_ready_q     <= 1'b1;
    end else begin
      state_q        <= state_d;
      byte_cnt_q     <= byte_cnt_d;
      chk_q          <= chk_d;
      word_q         <= word_d;
      n_q            <= n_d;
      words_loaded_q <= words_loaded_d;
      pm_we_q        <= pm_we_d;
      pm_addr_q      <= pm_addr_d;
      pm_data_q      <= pm_data_d;
      core_rst_q     <= core_rst_d;
      load_done_q    <= load_done_d;
      load_error_q   <= load_error_d;
      in_ready_q     <= in_ready_d;
    end
  end

  assign in_ready     = in_ready_q;
  assign pm_we        = pm_we_q;
  assign pm_addr      = pm_addr_q;
  assign pm_data      = pm_data_q;
  assign core_rst     = core_rst_q;
  assign load_done    = load_done_q;
  assign load_error   = load_error_q;
  assign words_loaded = words_loaded_q;

endmodule

// File: tb/tb_riscv_program_loader.sv
// Directed bench for riscv_program_loader: good frame, bad checksum, bad count,
// stalls, mid-frame reset, and junk before SYNC / bytes after completion.
module tb_riscv_program_loader;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       pm_we;
  logic [4:0] pm_addr;
  logic [31:0] pm_data;
  logic       core_rst;
  logic       load_done;
  logic       load_error;
  logic [5:0] words_loaded;

  int n_checks = 0;
  int n_pass   = 0;

  // Write log captured away from the clock edge.
  int         nw = 0;
  logic [4:0] wr_addr [0:63];
  logic [31:0] wr_data [0:63];

  logic [7:0] t1 [0:10];

  riscv_program_loader dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .pm_we(pm_we), .pm_addr(pm_addr), .pm_data(pm_data), .core_rst(core_rst),
    .load_done(load_done), .load_error(load_error), .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  // Record every write strobe.
  always @(negedge clk) begin
    if (pm_we === 1'b1 && nw < 64) begin
      wr_addr[nw] = pm_addr;
      wr_data[nw] = pm_data;
      nw++;
    end
  end

  initial begin
    #500000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    in_data  = b;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic reset_dut();
    in_valid = 1'b0;
    in_data  = 8'h00;
    rst      = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    nw  = 0;
  endtask

  task automatic send_t1(input logic [7:0] chk, input int max_gap);
    for (int i = 0; i < 11; i++) begin
      if (max_gap > 0) repeat ($urandom_range(0, max_gap)) tick();
      send_byte(i == 10 ? chk : t1[i]);
    end
  endtask

  task automatic check_t1(input string tag);
    n_checks++; if (nw !== 2) $display("FAIL %s nwrites: got %0d want 2", tag, nw); else n_pass++;
    n_checks++; if (wr_addr[0] !== 5'd0 || wr_data[0] !== 32'h00500093)
      $display("FAIL %s write0: got %0d/%h want 0/00500093", tag, wr_addr[0], wr_data[0]); else n_pass++;
    n_checks++; if (wr_addr[1] !== 5'd1 || wr_data[1] !== 32'h00100113)
      $display("FAIL %s write1: got %0d/%h want 1/00100113", tag, wr_addr[1], wr_data[1]); else n_pass++;
    n_checks++; if (load_done !== 1'b1 || core_rst !== 1'b0)
      $display("FAIL %s done: got done=%b core_rst=%b want 1/0", tag, load_done, core_rst); else n_pass++;
    n_checks++; if (words_loaded !== 6'd2) $display("FAIL %s words_loaded: got %0d want 2", tag, words_loaded); else n_pass++;
    n_checks++; if (in_ready !== 1'b0 || load_error !== 1'b0)
      $display("FAIL %s idle: got in_ready=%b err=%b want 0/0", tag, in_ready, load_error); else n_pass++;
  endtask

  task automatic check_reset_vals(input string tag);
    n_checks++;
    if (in_ready !== 1'b1 || pm_we !== 1'b0 || pm_addr !== 5'd0 || pm_data !== 32'h0 ||
        core_rst !== 1'b1 || load_done !== 1'b0 || load_error !== 1'b0 || words_loaded !== 6'd0)
      $display("FAIL %s: got rdy=%b we=%b addr=%0d data=%h crst=%b done=%b err=%b wl=%0d want 1 0 0 0 1 0 0 0",
               tag, in_ready, pm_we, pm_addr, pm_data, core_rst, load_done, load_error, words_loaded);
    else n_pass++;
  endtask

  task automatic test_reset();
    reset_dut();
    check_reset_vals("reset");
  endtask

  task automatic test_basic();
    reset_dut();
    for (int i = 0; i < 6; i++) send_byte(t1[i]);
    n_checks++; if (pm_we !== 1'b1 || pm_addr !== 5'd0 || pm_data !== 32'h00500093)
      $display("FAIL basic latency: got we=%b addr=%0d data=%h want 1/0/00500093", pm_we, pm_addr, pm_data); else n_pass++;
    tick();
    n_checks++; if (pm_we !== 1'b0 || pm_data !== 32'h00500093)
      $display("FAIL basic pulse: got we=%b data=%h want 0/00500093", pm_we, pm_data); else n_pass++;
    for (int i = 6; i < 10; i++) send_byte(t1[i]);
    n_checks++; if (core_rst !== 1'b1 || load_done !== 1'b0)
      $display("FAIL basic pre_chk: got crst=%b done=%b want 1/0", core_rst, load_done); else n_pass++;
    send_byte(8'hC1);
    check_t1("basic");
  endtask

  task automatic test_bad_chk();
    reset_dut();
    send_t1(8'hC0, 0);
    n_checks++; if (load_error !== 1'b1 || core_rst !== 1'b1 || in_ready !== 1'b1 || load_done !== 1'b0)
      $display("FAIL badchk: got err=%b crst=%b rdy=%b done=%b want 1 1 1 0", load_error, core_rst, in_ready, load_done); else n_pass++;
    nw = 0;
    send_t1(8'hC1, 0);
    check_t1("badchk_retry");
  endtask

  task automatic test_bad_count();
    reset_dut();
    send_byte(8'hA5);
    send_byte(8'h00);
    n_checks++; if (load_error !== 1'b1) $display("FAIL count0 err: got %b want 1", load_error); else n_pass++;
    send_byte(8'hA5);
    n_checks++; if (load_error !== 1'b0) $display("FAIL count resync: got err=%b want 0", load_error); else n_pass++;
    send_byte(8'h21);
    n_checks++; if (load_error !== 1'b1 || core_rst !== 1'b1)
      $display("FAIL count33 err: got err=%b crst=%b want 1/1", load_error, core_rst); else n_pass++;
    repeat (6) send_byte(8'h13);
    n_checks++; if (nw !== 0 || load_error !== 1'b1)
      $display("FAIL count nowrite: got writes=%0d err=%b want 0/1", nw, load_error); else n_pass++;
  endtask

  task automatic test_gaps();
    reset_dut();
    send_t1(8'hC1, 5);
    check_t1("gaps");
  endtask

  task automatic test_mid_reset();
    reset_dut();
    for (int i = 0; i < 7; i++) send_byte(t1[i]);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset_vals("midrst");
    nw = 0;
    send_t1(8'hC1, 0);
    check_t1("midrst_retry");
  endtask

  task automatic test_junk_and_done();
    reset_dut();
    send_byte(8'h00);
    send_byte(8'hFF);
    send_byte(8'h13);
    n_checks++; if (in_ready !== 1'b1 || load_error !== 1'b0 || nw !== 0)
      $display("FAIL junk: got rdy=%b err=%b writes=%0d want 1 0 0", in_ready, load_error, nw); else n_pass++;
    send_t1(8'hC1, 0);
    check_t1("junk");
    send_byte(8'hA5);
    send_byte(8'h01);
    repeat (5) send_byte(8'h00);
    n_checks++; if (load_done !== 1'b1 || core_rst !== 1'b0 || nw !== 2 || in_ready !== 1'b0)
      $display("FAIL done_hold: got done=%b crst=%b writes=%0d rdy=%b want 1 0 2 0", load_done, core_rst, nw, in_ready); else n_pass++;
  endtask

  initial begin
    t1[0] = 8'hA5; t1[1] = 8'h02;
    t1[2] = 8'h93; t1[3] = 8'h00; t1[4] = 8'h50; t1[5] = 8'h00;
    t1[6] = 8'h13; t1[7] = 8'h01; t1[8] = 8'h10; t1[9] = 8'h00;
    t1[10] = 8'hC1;
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = 8'h00;
    test_reset();
    test_basic();
    test_bad_chk();
    test_bad_count();
    test_gaps();
    test_mid_reset();
    test_junk_and_done();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
